// File: rtl/wb_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_bist_pkg
// Brief    : Shared types and constants for the Wishbone BIST master.
//            The LFSR taps and the substitute for a zero seed are defined here.
// Revision : 1.0 - initial release
// ============================================================================
package wb_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0]  CTI_CLASSIC        = 3'b000;
    localparam logic [1:0]  BTE_LINEAR         = 2'b00;

    localparam int          LFSR_TAP_A         = 31;
    localparam int          LFSR_TAP_B         = 21;
    localparam int          LFSR_TAP_C         = 1;
    localparam int          LFSR_TAP_D         = 0;
    localparam logic [31:0] LFSR_ZERO_SEED_SUB = 32'h0000_0001;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {cur[30:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D]};
    endfunction

    // An all-zero LFSR would lock up, so zero is replaced.
    function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] seed);
        return (seed == 32'd0) ? LFSR_ZERO_SEED_SUB : seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bist_master_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_bist_master_if
// Brief    : Wishbone classic bus bundle between the BIST master and a slave.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_bist_master_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic [aw-1:0] wbm_adr_o;
    logic [1:0]    wbm_bte_o;
    logic [2:0]    wbm_cti_o;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [dw-1:0] wbm_dat_o;
    logic [dw-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;
    logic          wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_bte_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
               wbm_we_o, wbm_sel_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_bte_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
               wbm_we_o, wbm_sel_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : wb_bist_lfsr
// Brief    : 32-bit Fibonacci LFSR pattern source with synchronous reload.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bist_lfsr
    import wb_bist_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load,
    input  wire logic [31:0] seed,
    input  wire logic        step,
    output logic      [31:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_ZERO_SEED_SUB;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_bist_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_bist_master
// Brief    : Wishbone classic master that writes an LFSR pattern, reads it
//            back and reports mismatches. WB_BIST_MASTER_TIMEOUT_EN adds a
//            per-transfer watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bist_master
    import wb_bist_pkg::*;
#(
    parameter int dw    = 32,
    parameter int aw    = 32,
    parameter int len_w = 16
`ifdef WB_BIST_MASTER_TIMEOUT_EN
    ,
    parameter int timeout_cycles = 1024
`endif
) (
    input  wire logic             wb_clk_i,
    input  wire logic             wb_rst_i,
    input  wire logic             start_i,
    input  wire logic [aw-1:0]    base_adr_i,
    input  wire logic [len_w-1:0] len_i,
    input  wire logic [31:0]      seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [len_w-1:0]      err_cnt_o,
    output logic [aw-1:0]         first_err_adr_o,
    output logic                  bus_err_o,
    output logic                  timeout_o,
    wb_bist_master_if.master      wbm
);

    state_t           r_state;
    logic [aw-1:0]    r_base;
    logic [aw-1:0]    r_adr;
    logic [dw-1:0]    r_dat;
    logic [len_w-1:0] r_len;
    logic [len_w-1:0] r_cnt;
    logic [31:0]      r_seed;
    logic [len_w-1:0] r_err_cnt;
    logic [aw-1:0]    r_first_err;
    logic             r_cyc, r_we, r_busy, r_done, r_pass, r_bus_err, r_timeout;

    logic [31:0]      w_lfsr;
    logic [31:0]      w_seed;
    logic [aw-1:0]    w_base;
    logic             w_start, w_active, w_last, w_ack, w_mismatch, w_timeout;
    logic             w_lfsr_load;
    logic [1:0]       w_unused_adr_lsb;

    assign w_seed           = lfsr_seed_fix(seed_i);
    assign w_base           = {base_adr_i[aw-1:2], 2'b00};
    assign w_unused_adr_lsb = base_adr_i[1:0];
    assign w_start          = start_i && (r_state == IDLE || r_state == DONE);
    assign w_active         = r_cyc && (r_state == WRITE || r_state == READ);
    assign w_last           = (r_cnt == len_w'(1));
    assign w_ack            = w_active && wbm.wbm_ack_i && !wbm.wbm_err_i;
    assign w_mismatch       = (wbm.wbm_dat_i != w_lfsr);
    assign w_lfsr_load      = w_start || (r_state == WRITE && w_ack && w_last);

`ifdef WB_BIST_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(timeout_cycles + 1);
    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = w_active && !wbm.wbm_ack_i && !wbm.wbm_err_i && !wbm.wbm_rty_i
                       && (r_to_cnt == TO_W'(timeout_cycles - 1));

    // Counts clocks the current strobe has waited without any response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !r_cyc || wbm.wbm_ack_i || wbm.wbm_rty_i) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    wb_bist_lfsr u_lfsr (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .load  (w_lfsr_load),
        .seed  (w_start ? w_seed : r_seed),
        .step  (w_ack),
        .value (w_lfsr)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_seed      <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_bus_err   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_base      <= w_base;
                        r_adr       <= w_base;
                        r_dat       <= w_seed;
                        r_seed      <= w_seed;
                        r_len       <= len_i;
                        r_cnt       <= len_i;
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        r_bus_err   <= 1'b0;
                        r_timeout   <= 1'b0;
                        if (len_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= WRITE;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b1;
                        end
                    end
                end
                default: begin
                    // err outranks ack; rty alone leaves everything unchanged.
                    if (w_active && (wbm.wbm_err_i || w_timeout)) begin
                        r_bus_err <= wbm.wbm_err_i;
                        r_timeout <= !wbm.wbm_err_i;
                        r_cyc     <= 1'b0;
                        r_we      <= 1'b0;
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_pass    <= 1'b0;
                    end else if (w_ack && r_state == WRITE) begin
                        if (w_last) begin
                            r_state <= READ;
                            r_we    <= 1'b0;
                            r_adr   <= r_base;
                            r_cnt   <= r_len;
                        end else begin
                            r_adr   <= r_adr + aw'(4);
                            r_dat   <= lfsr_next(w_lfsr);
                            r_cnt   <= r_cnt - len_w'(1);
                        end
                    end else if (w_ack) begin
                        if (w_mismatch) begin
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + len_w'(1);
                            end
                            if (r_err_cnt == '0) begin
                                r_first_err <= r_adr;
                            end
                        end
                        if (w_last) begin
                            r_cyc   <= 1'b0;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_pass  <= (r_err_cnt == '0) && !w_mismatch;
                        end else begin
                            r_adr   <= r_adr + aw'(4);
                            r_cnt   <= r_cnt - len_w'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign pass_o          = r_pass;
    assign err_cnt_o       = r_err_cnt;
    assign first_err_adr_o = r_first_err;
    assign bus_err_o       = r_bus_err;
    assign timeout_o       = r_timeout;

    assign wbm.wbm_adr_o = r_adr;
    assign wbm.wbm_dat_o = r_dat;
    assign wbm.wbm_cyc_o = r_cyc;
    assign wbm.wbm_stb_o = r_cyc;
    assign wbm.wbm_we_o  = r_we;
    assign wbm.wbm_sel_o = 4'hF;
    assign wbm.wbm_cti_o = CTI_CLASSIC;
    assign wbm.wbm_bte_o = BTE_LINEAR;

endmodule
`default_nettype wire

// File: tb/tb_wb_bist_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bist_master
// Brief    : Randomised self-checking bench for wb_bist_master with a memory
//            slave model and a pattern/expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bist_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base = '0;
    logic [LW-1:0] len = '0;
    logic [31:0]   seed = '0;
    logic          busy, done, pass, bus_err, timeout;
    logic [LW-1:0] err_cnt;
    logic [31:0]   first_adr;

    wb_bist_master_if #(.aw(AW), .dw(DW)) wbm_if ();

    wb_bist_master #(.dw(DW), .aw(AW), .len_w(LW)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .start_i         (start),
        .base_adr_i      (base),
        .len_i           (len),
        .seed_i          (seed),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .err_cnt_o       (err_cnt),
        .first_err_adr_o (first_adr),
        .bus_err_o       (bus_err),
        .timeout_o       (timeout),
        .wbm             (wbm_if.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] v);
        logic fb;
        fb = v[31] ^ v[21] ^ v[1] ^ v[0];
        return (v << 1) | {31'd0, fb};
    endfunction

    // Slave memory model and transaction logs
    logic [31:0] mem [logic [31:0]];
    bit          corrupt [logic [31:0]];
    logic [31:0] wr_adr_q[$], wr_dat_q[$], rd_adr_q[$];
    int          xfer, rty_at, err_at, wait_left, max_wait, err_cyc;
    bit          rty_done;
    logic [31:0] rty_adr, rty_dat;

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    initial begin
        wbm_if.wbm_ack_i = 1'b0;
        wbm_if.wbm_err_i = 1'b0;
        wbm_if.wbm_rty_i = 1'b0;
        wbm_if.wbm_dat_i = '0;
        wait_left = 0;
        forever begin
            @(posedge clk);
            #1;
            wbm_if.wbm_ack_i = 1'b0;
            wbm_if.wbm_err_i = 1'b0;
            wbm_if.wbm_rty_i = 1'b0;
            if (rst) begin
                wait_left = 0;
            end else if (wbm_if.wbm_cyc_o && wbm_if.wbm_stb_o) begin
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    wait_left = $urandom_range(0, max_wait);
                    if (rty_at == xfer && !rty_done) begin
                        wbm_if.wbm_rty_i = 1'b1;
                        rty_done = 1'b1;
                        rty_adr  = wbm_if.wbm_adr_o;
                        rty_dat  = wbm_if.wbm_dat_o;
                    end else if (err_at == xfer) begin
                        wbm_if.wbm_err_i = 1'b1;
                        wbm_if.wbm_ack_i = 1'b1;
                        err_cyc = cyc_n;
                    end else begin
                        wbm_if.wbm_ack_i = 1'b1;
                        xfer++;
                        if (wbm_if.wbm_we_o) begin
                            mem[wbm_if.wbm_adr_o] = wbm_if.wbm_dat_o;
                            wr_adr_q.push_back(wbm_if.wbm_adr_o);
                            wr_dat_q.push_back(wbm_if.wbm_dat_o);
                        end else begin
                            wbm_if.wbm_dat_i = mem[wbm_if.wbm_adr_o] ^
                                (corrupt.exists(wbm_if.wbm_adr_o) ? 32'd1 : 32'd0);
                            rd_adr_q.push_back(wbm_if.wbm_adr_o);
                        end
                    end
                end
            end
        end
    end

    logic [31:0] exp_adr[$], exp_dat[$];
    int          exp_errs;
    logic [31:0] exp_first;

    task automatic prep(input logic [31:0] b, input int n, input logic [31:0] s,
                        input logic [31:0] mask, input bit errmode);
        logic [31:0] v, a;
        exp_adr.delete(); exp_dat.delete(); corrupt.delete();
        wr_adr_q.delete(); wr_dat_q.delete(); rd_adr_q.delete();
        v = (s == 0) ? 32'd1 : s;
        a = b & 32'hFFFF_FFFC;
        exp_errs = 0; exp_first = '0;
        for (int i = 0; i < n; i++) begin
            exp_adr.push_back(a + 32'(4 * i));
            exp_dat.push_back(v);
            v = model_next(v);
            if (i < 32 && mask[i] && !errmode) begin
                corrupt[exp_adr[i]] = 1'b1;
                if (exp_errs == 0) exp_first = exp_adr[i];
                exp_errs++;
            end
        end
        xfer = 0; rty_done = 1'b0; err_cyc = 0;
        rty_at = errmode ? 1 : -1;
        err_at = errmode ? 2 : -1;
        base = b; len = LW'(n); seed = s;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_test(input logic [31:0] b, input int n, input logic [31:0] s,
                            input logic [31:0] mask, input bit errmode);
        int  k, n_wr, n_rd;
        bit  seen;
        prep(b, n, s, mask, errmode);
        if (n == 0) begin
            chk("len0_done", done, 1'b1);
            chk("len0_pass", pass, 1'b1);
            for (int i = 0; i < 4; i++) begin
                chk("len0_cyc", wbm_if.wbm_cyc_o, 1'b0);
                @(posedge clk); #1;
            end
            return;
        end
        chk("start_cyc", {wbm_if.wbm_cyc_o, wbm_if.wbm_stb_o, wbm_if.wbm_we_o}, 3'b111);
        chk("start_adr", wbm_if.wbm_adr_o, exp_adr[0]);
        chk("start_dat", wbm_if.wbm_dat_o, exp_dat[0]);
        chk("start_busy", {busy, done}, 2'b10);
        seen = 1'b0;
        for (k = 0; k < n * 8 + 40; k++) begin
            if (done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("done_seen", seen, 1'b1);
        chk("end_flags", {busy, wbm_if.wbm_cyc_o, timeout}, 3'b000);
        n_wr = errmode ? 2 : n;
        n_rd = errmode ? 0 : n;
        chk("wr_count", wr_adr_q.size(), n_wr);
        chk("rd_count", rd_adr_q.size(), n_rd);
        for (int i = 0; i < n_wr && i < wr_adr_q.size(); i++) begin
            chk($sformatf("wr_adr[%0d]", i), wr_adr_q[i], exp_adr[i]);
            chk($sformatf("wr_dat[%0d]", i), wr_dat_q[i], exp_dat[i]);
        end
        for (int i = 0; i < n_rd && i < rd_adr_q.size(); i++)
            chk($sformatf("rd_adr[%0d]", i), rd_adr_q[i], exp_adr[i]);
        if (errmode) begin
            chk("rty_adr", rty_adr, exp_adr[1]);
            chk("rty_dat", rty_dat, exp_dat[1]);
            chk("bus_err", {bus_err, pass}, 2'b10);
            chk("err_drop_lat", cyc_n - err_cyc, 1);
        end else begin
            chk("bus_err", bus_err, 1'b0);
            chk("err_cnt", err_cnt, LW'(exp_errs));
            chk("first_adr", first_adr, exp_first);
            chk("pass", pass, exp_errs == 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_status"}, {busy, done, pass, bus_err, timeout}, 5'b0);
        chk({tag, "_bus"}, {wbm_if.wbm_cyc_o, wbm_if.wbm_stb_o, wbm_if.wbm_we_o}, 3'b0);
        chk({tag, "_err"}, {err_cnt, first_adr}, '0);
        chk({tag, "_adrdat"}, {wbm_if.wbm_adr_o, wbm_if.wbm_dat_o}, '0);
    endtask

    initial begin
        bit seen;
        max_wait = 0;
        rty_at = -1; err_at = -1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        chk("consts", {wbm_if.wbm_sel_o, wbm_if.wbm_cti_o, wbm_if.wbm_bte_o}, {4'hF, 3'b000, 2'b00});
        rst = 1'b0;

        run_test(32'h0000_0100, 4, 32'h1, 32'h0, 1'b0);
        run_test(32'h0000_0100, 4, 32'h1, 32'h4, 1'b0);
        max_wait = 2;
        run_test(32'h0000_0200, 6, 32'hACE1_0001, 32'h0, 1'b1);
        run_test(32'h0000_0000, 0, 32'h5, 32'h0, 1'b0);
        run_test(32'hFFFF_FFF8, 4, 32'h1234_5678, 32'h0, 1'b0);
        run_test(32'h0000_0043, 5, 32'h0, 32'h0, 1'b0);

        for (int t = 0; t < 6; t++)
            run_test($urandom() & 32'h000F_FFFF, $urandom_range(1, 16), $urandom(),
                     ($urandom_range(0, 1) == 1) ? $urandom() : 32'h0, 1'b0);

        // Reset while the read phase is in progress
        max_wait = 1;
        prep(32'h0000_0800, 6, 32'h0BAD_F00D, 32'h0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rd_adr_q.size() >= 1) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("reach_read", seen, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("midrst");
        rst = 1'b0;
        run_test(32'h0000_0900, 5, 32'h0000_0077, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
